// File: rtl/dpram_arbiter_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
package dpram_arbiter_pkg;

    localparam int VECTOR_BITS = 1024;
    localparam int NUM_WORDS   = 32;
    localparam int ADDR_BITS   = $clog2(NUM_WORDS);

    // Binary index of a one-hot vector (up to 8 requesters); zero for an empty vector.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic find-first-set: picks the first eligible request at or after a start pointer.
module rr_pick #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt,
    output logic          found
);

    logic [N-1:0] elig;
    int           idx;

    assign elig = req & mask;

    // Walk N positions from start, wrapping; the first eligible one wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping up to two requesters per cycle onto the A/B ports
// of a dual-port RAM with registered read data, and routing read data back.
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  AWIDTH  = ADDR_BITS,
    parameter int  DWIDTH  = VECTOR_BITS,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp0_valid,
    output logic                      rsp1_valid,
    output logic [IW-1:0]             rsp0_id,
    output logic [IW-1:0]             rsp1_id,
    output logic [DWIDTH-1:0]         rsp0_data,
    output logic [DWIDTH-1:0]         rsp1_data,
    output logic [AWIDTH-1:0]         address_a,
    output logic [AWIDTH-1:0]         address_b,
    output logic                      wren_a,
    output logic                      wren_b,
    output logic [DWIDTH-1:0]         data_a,
    output logic [DWIDTH-1:0]         data_b,
    input  logic [DWIDTH-1:0]         out_a,
    input  logic [DWIDTH-1:0]         out_b
);

    logic [NUM_REQ-1:0][AWIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DWIDTH-1:0] wdata_v;
    logic [NUM_REQ-1:0]             gnt_a;
    logic [NUM_REQ-1:0]             gnt_b;
    logic [NUM_REQ-1:0]             mask_b;
    logic                           found_a;
    logic                           found_b;
    logic                           grant_a;
    logic                           grant_b;
    logic [IW-1:0]                  idx_a;
    logic [IW-1:0]                  idx_b;
    logic [IW-1:0]                  start_b;
    logic [IW-1:0]                  ptr;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .req   (req),
        .start (ptr),
        .mask  ({NUM_REQ{1'b1}}),
        .gnt   (gnt_a),
        .found (found_a)
    );

    assign idx_a   = IW'(onehot_to_index(8'(gnt_a)));
    assign start_b = wrap_inc(idx_a);

    // Port B may not take the port-A winner, nor a write to the address port A is writing.
    always_comb begin
        mask_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            mask_b[j] = (IW'(j) != idx_a) &&
                        !(req_we[j] && req_we[idx_a] && (addr_v[j] == addr_v[idx_a]));
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .req   (req),
        .start (start_b),
        .mask  (mask_b),
        .gnt   (gnt_b),
        .found (found_b)
    );

    assign idx_b   = IW'(onehot_to_index(8'(gnt_b)));
    assign grant_a = found_a && resetn;
    assign grant_b = found_b && resetn;
    assign gnt     = resetn ? (gnt_a | gnt_b) : '0;

    // Drive each RAM port from its winner; an idle port is held at zero.
    always_comb begin
        address_a = '0;
        wren_a    = 1'b0;
        data_a    = '0;
        address_b = '0;
        wren_b    = 1'b0;
        data_b    = '0;
        if (grant_a) begin
            address_a = addr_v[idx_a];
            wren_a    = req_we[idx_a];
            data_a    = wdata_v[idx_a];
        end
        if (grant_b) begin
            address_b = addr_v[idx_b];
            wren_b    = req_we[idx_b];
            data_b    = wdata_v[idx_b];
        end
    end

    // Advance the round-robin pointer and tag read responses to line up with RAM read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr        <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_id    <= '0;
            rsp1_id    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (found_b) begin
                ptr <= wrap_inc(idx_b);
            end else if (found_a) begin
                ptr <= wrap_inc(idx_a);
            end
            rsp0_valid <= found_a && !req_we[idx_a];
            rsp1_valid <= found_b && !req_we[idx_b];
            rsp0_id    <= idx_a;
            rsp1_id    <= idx_b;
        end
    end

    assign rsp0_data = out_a;
    assign rsp1_data = out_b;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM and a response scoreboard.
module tb_dpram_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AWIDTH  = 5;
    localparam int DWIDTH  = 1024;

    logic                            clk = 1'b0;
    logic                            resetn;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ-1:0][AWIDTH-1:0]  req_addr;
    logic [NUM_REQ-1:0][DWIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]              gnt;
    logic                            rsp0_valid;
    logic                            rsp1_valid;
    logic [1:0]                      rsp0_id;
    logic [1:0]                      rsp1_id;
    logic [DWIDTH-1:0]               rsp0_data;
    logic [DWIDTH-1:0]               rsp1_data;
    logic [AWIDTH-1:0]               address_a;
    logic [AWIDTH-1:0]               address_b;
    logic                            wren_a;
    logic                            wren_b;
    logic [DWIDTH-1:0]               data_a;
    logic [DWIDTH-1:0]               data_b;
    logic [DWIDTH-1:0]               out_a;
    logic [DWIDTH-1:0]               out_b;

    logic [DWIDTH-1:0] mem [32];
    logic              mem_ready = 1'b0;

    typedef struct {
        logic [1:0]        id;
        logic [DWIDTH-1:0] data;
    } rsp_t;

    rsp_t exp_q0[$];
    rsp_t exp_q1[$];
    rsp_t e0;
    rsp_t e1;
    int   tests = 0;
    int   fails = 0;
    int   last2;

    dpram_arbiter #(.NUM_REQ(NUM_REQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_id    (rsp0_id),
        .rsp1_id    (rsp1_id),
        .rsp0_data  (rsp0_data),
        .rsp1_data  (rsp1_data),
        .address_a  (address_a),
        .address_b  (address_b),
        .wren_a     (wren_a),
        .wren_b     (wren_b),
        .data_a     (data_a),
        .data_b     (data_b),
        .out_a      (out_a),
        .out_b      (out_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wpat(input int i);
        return 32'h1000 + 32'(i);
    endfunction

    // Dual-port RAM: registered read returning the pre-write contents.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= DWIDTH'(wpat(i));
            mem_ready <= 1'b1;
        end else begin
            out_a <= mem[address_a];
            out_b <= mem[address_b];
            if (wren_a) mem[address_a] <= data_a;
            if (wren_b) mem[address_b] <= data_b;
        end
    end

    task automatic check(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic expect_rsp(input int ch, input logic [1:0] id, input logic [31:0] d);
        rsp_t r;
        r.id   = id;
        r.data = DWIDTH'(d);
        if (ch == 0) exp_q0.push_back(r);
        else         exp_q1.push_back(r);
    endtask

    task automatic idle_all();
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic we, input logic [AWIDTH-1:0] a, input logic [31:0] d);
        req[i]       = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = DWIDTH'(d);
    endtask

    // One cycle: check grant and both RAM ports mid-cycle, then advance past the edge.
    task automatic step(input string name, input logic [3:0] eg,
                        input logic [4:0] ea, input logic ewa, input logic [31:0] eda,
                        input logic [4:0] eb, input logic ewb, input logic [31:0] edb);
        @(negedge clk);
        check({name, "_gnt"},       DWIDTH'(gnt),       DWIDTH'(eg));
        check({name, "_address_a"}, DWIDTH'(address_a), DWIDTH'(ea));
        check({name, "_wren_a"},    DWIDTH'(wren_a),    DWIDTH'(ewa));
        check({name, "_data_a"},    data_a,             DWIDTH'(eda));
        check({name, "_address_b"}, DWIDTH'(address_b), DWIDTH'(eb));
        check({name, "_wren_b"},    DWIDTH'(wren_b),    DWIDTH'(ewb));
        check({name, "_data_b"},    data_b,             DWIDTH'(edb));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response must match the oldest expectation on its channel.
    always @(negedge clk) begin
        if (rsp0_valid) begin
            if (exp_q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp0_unexpected: actual id %0d required no response", rsp0_id);
            end else begin
                e0 = exp_q0.pop_front();
                check("rsp0_id",   DWIDTH'(rsp0_id), DWIDTH'(e0.id));
                check("rsp0_data", rsp0_data,        e0.data);
            end
        end
        if (rsp1_valid) begin
            if (exp_q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp1_unexpected: actual id %0d required no response", rsp1_id);
            end else begin
                e1 = exp_q1.pop_front();
                check("rsp1_id",   DWIDTH'(rsp1_id), DWIDTH'(e1.id));
                check("rsp1_data", rsp1_data,        e1.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b1;
        idle_all();
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, AWIDTH'(i), 32'h0);
        #2 resetn = 1'b0;

        // Reset with all requests asserted.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt",    DWIDTH'(gnt),        '0);
            check("rst_wren_a", DWIDTH'(wren_a),     '0);
            check("rst_wren_b", DWIDTH'(wren_b),     '0);
            check("rst_rsp0_v", DWIDTH'(rsp0_valid), '0);
            check("rst_rsp1_v", DWIDTH'(rsp1_valid), '0);
            check("rst_rsp0_id", DWIDTH'(rsp0_id),   '0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;

        // Round robin over four readers.
        expect_rsp(0, 2'd0, wpat(0)); expect_rsp(1, 2'd1, wpat(1));
        step("rr1", 4'b0011, 5'd0, 1'b0, 32'h0, 5'd1, 1'b0, 32'h0);
        expect_rsp(0, 2'd2, wpat(2)); expect_rsp(1, 2'd3, wpat(3));
        step("rr2", 4'b1100, 5'd2, 1'b0, 32'h0, 5'd3, 1'b0, 32'h0);
        expect_rsp(0, 2'd0, wpat(0)); expect_rsp(1, 2'd1, wpat(1));
        step("rr3", 4'b0011, 5'd0, 1'b0, 32'h0, 5'd1, 1'b0, 32'h0);
        idle_all();
        step("idle1", 4'b0000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Move the pointer back to 0 (pointer is 2 here).
        drive(3, 1'b0, 5'd3, 32'h0);
        expect_rsp(0, 2'd3, wpat(3));
        step("ptr0_a", 4'b1000, 5'd3, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Two writes to the same address: second one waits a cycle.
        idle_all();
        drive(0, 1'b1, 5'd7, 32'hAAAA);
        drive(1, 1'b1, 5'd7, 32'hBBBB);
        step("wconf1", 4'b0001, 5'd7, 1'b1, 32'hAAAA, 5'd0, 1'b0, 32'h0);
        req[0] = 1'b0;
        step("wconf2", 4'b0010, 5'd7, 1'b1, 32'hBBBB, 5'd0, 1'b0, 32'h0);
        idle_all();
        drive(0, 1'b0, 5'd7, 32'h0);
        expect_rsp(0, 2'd0, 32'hBBBB);
        step("rd7", 4'b0001, 5'd7, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Pointer back to 0 again (pointer is 1 here).
        idle_all();
        drive(3, 1'b0, 5'd0, 32'h0);
        expect_rsp(0, 2'd3, wpat(0));
        step("ptr0_b", 4'b1000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Read and write of one address in the same cycle: read sees the old word.
        idle_all();
        drive(0, 1'b1, 5'd3, 32'h5555);
        drive(1, 1'b0, 5'd3, 32'h0);
        expect_rsp(1, 2'd1, wpat(3));
        step("rwcol", 4'b0011, 5'd3, 1'b1, 32'h5555, 5'd3, 1'b0, 32'h0);
        idle_all();
        drive(2, 1'b0, 5'd3, 32'h0);
        expect_rsp(0, 2'd2, 32'h5555);
        step("rd3", 4'b0100, 5'd3, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        idle_all();
        step("idle2", 4'b0000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Starvation: requester 2 held while 0 and 3 toggle (all writes, distinct addresses).
        drive(2, 1'b1, 5'd22, 32'h22);
        drive(0, 1'b1, 5'd20, 32'h20);
        drive(3, 1'b1, 5'd23, 32'h23);
        last2 = -1;
        for (int c = 0; c < 20; c++) begin
            req[0] = 1'($urandom_range(0, 1));
            req[3] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("starve_subset", DWIDTH'(gnt & ~req), '0);
            if (gnt[2]) last2 = c;
            if (c >= 3) check("starve_window", DWIDTH'((c - last2) < 4), DWIDTH'(1));
            @(posedge clk);
            #1;
        end

        // Reset pulse in the middle of a granted read: no response may follow.
        idle_all();
        drive(0, 1'b0, 5'd1, 32'h0);
        @(negedge clk);
        check("rstmid_gnt", DWIDTH'(gnt), DWIDTH'(4'b0001));
        resetn = 1'b0;
        @(posedge clk);
        #1 idle_all();
        check("rstmid_rsp0_v", DWIDTH'(rsp0_valid), '0);
        check("rstmid_rsp1_v", DWIDTH'(rsp1_valid), '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rel_rsp0_v", DWIDTH'(rsp0_valid), '0);
        check("rel_rsp1_v", DWIDTH'(rsp1_valid), '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, AWIDTH'(i), 32'h0);
        expect_rsp(0, 2'd0, wpat(0)); expect_rsp(1, 2'd1, wpat(1));
        step("rel_ptr0", 4'b0011, 5'd0, 1'b0, 32'h0, 5'd1, 1'b0, 32'h0);
        idle_all();
        step("idle3", 4'b0000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step("idle4", 4'b0000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        check("q0_drained", DWIDTH'(exp_q0.size()), '0);
        check("q1_drained", DWIDTH'(exp_q1.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
